// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage; ALU results pass straight through, loads/stores run a stalling IDLE/WAIT/DONE handshake.
// Optional MEM_TIMEOUT_EN adds a 15-cycle WAIT timeout with a mem_err pulse. Rev 1.0
`default_nettype none

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        memtoreg,
    input  logic        regwrite,
    input  logic [15:0] alu_result,
    input  logic [15:0] store_data,
    input  logic [3:0]  reg_write_select,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        out_valid,
    output logic        regwrite_out,
    output logic [15:0] reg_write_data_out,
    output logic [3:0]  reg_write_select_out
`ifdef MEM_TIMEOUT_EN
    ,
    output logic        mem_err
`endif
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]  state, next_state;
    logic [15:0] lat_addr, lat_wdata, lat_rdata;
    logic [3:0]  lat_sel;
    logic        lat_regwrite, lat_memtoreg, lat_we;
    logic        squash;
    logic        start;
    logic        timed_out;

    // A flushed instruction never opens a memory transaction.
    assign start = in_valid & (memread | memwrite) & ~flush;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       tout_flag;
    assign timed_out = (state == S_WAIT) & ~mem_ack & (wait_cnt == 4'd14);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= 4'd0;
            tout_flag <= 1'b0;
        end else if (state == S_IDLE && start) begin
            wait_cnt  <= 4'd0;
            tout_flag <= 1'b0;
        end else if (state == S_WAIT && !mem_ack) begin
            wait_cnt  <= wait_cnt + 4'd1;
            if (timed_out)
                tout_flag <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:  next_state = start ? S_WAIT : S_IDLE;
            S_WAIT:  next_state = (mem_ack || timed_out) ? S_DONE : S_WAIT;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr     <= 16'd0;
            lat_wdata    <= 16'd0;
            lat_rdata    <= 16'd0;
            lat_sel      <= 4'd0;
            lat_regwrite <= 1'b0;
            lat_memtoreg <= 1'b0;
            lat_we       <= 1'b0;
            squash       <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                lat_addr     <= alu_result;
                lat_wdata    <= store_data;
                lat_sel      <= reg_write_select;
                lat_regwrite <= regwrite;
                lat_memtoreg <= memtoreg;
                lat_we       <= memwrite;
            end
            if (state == S_WAIT && mem_ack)
                lat_rdata <= mem_rdata;
            if (next_state == S_IDLE)
                squash <= 1'b0;
            else if (state == S_WAIT && flush)
                squash <= 1'b1;
        end
    end

    // Outputs are forced low while reset is held, even if upstream shows a live op.
    always_comb begin
        mem_req              = 1'b0;
        mem_we               = 1'b0;
        mem_addr             = 16'd0;
        mem_wdata            = 16'd0;
        stall                = 1'b0;
        out_valid            = 1'b0;
        regwrite_out         = 1'b0;
        reg_write_data_out   = 16'd0;
        reg_write_select_out = 4'd0;
`ifdef MEM_TIMEOUT_EN
        mem_err              = 1'b0;
`endif
        if (rst) begin
            case (state)
                S_IDLE: begin
                    stall                = start;
                    out_valid            = in_valid & ~start;
                    regwrite_out         = in_valid & ~start & regwrite & ~flush;
                    reg_write_data_out   = alu_result;
                    reg_write_select_out = reg_write_select;
                end
                S_WAIT: begin
                    mem_req   = 1'b1;
                    mem_we    = lat_we;
                    mem_addr  = lat_addr;
                    mem_wdata = lat_wdata;
                    stall     = 1'b1;
                end
                S_DONE: begin
                    out_valid            = 1'b1;
                    reg_write_data_out   = lat_memtoreg ? lat_rdata : lat_addr;
                    reg_write_select_out = lat_sel;
`ifdef MEM_TIMEOUT_EN
                    regwrite_out         = lat_regwrite & ~squash & ~tout_flag;
                    mem_err              = tout_flag;
`else
                    regwrite_out         = lat_regwrite & ~squash;
`endif
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a writeback scoreboard; define MEM_TIMEOUT_EN to cover the timeout path.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, memread, memwrite, memtoreg, regwrite, flush;
    logic [15:0] alu_result, store_data, mem_rdata;
    logic [3:0]  reg_write_select;
    logic        mem_ack;
    logic        mem_req, mem_we, stall, out_valid, regwrite_out;
    logic [15:0] mem_addr, mem_wdata, reg_write_data_out;
    logic [3:0]  reg_write_select_out;
`ifdef MEM_TIMEOUT_EN
    logic        mem_err;
`endif

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .alu_result(alu_result), .store_data(store_data),
        .reg_write_select(reg_write_select), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .out_valid(out_valid), .regwrite_out(regwrite_out),
        .reg_write_data_out(reg_write_data_out), .reg_write_select_out(reg_write_select_out)
`ifdef MEM_TIMEOUT_EN
        , .mem_err(mem_err)
`endif
    );

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  sel;
        logic        rw;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [3:0] s, input logic rw);
        exp_t e;
        e.data = d;
        e.sel  = s;
        e.rw   = rw;
        sb.push_back(e);
    endtask

    // Writeback monitor: every out_valid must match the oldest expected entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected out_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wb data", 64'(reg_write_data_out), 64'(e.data));
                chk("wb sel", 64'(reg_write_select_out), 64'(e.sel));
                chk("wb regwrite", 64'(regwrite_out), 64'(e.rw));
            end
        end
    end

    task automatic idle_inputs();
        in_valid = 0; memread = 0; memwrite = 0; memtoreg = 0; regwrite = 0; flush = 0;
        mem_ack = 0; alu_result = 0; store_data = 0; reg_write_select = 0; mem_rdata = 0;
    endtask

    task automatic alu_op(input logic [15:0] a, input logic [3:0] s, input logic rw, input logic fl);
        @(posedge clk) #1;
        in_valid = 1; regwrite = rw; alu_result = a; reg_write_select = s; flush = fl;
        push_exp(a, s, rw & ~fl);
        @(negedge clk);
        chk("alu stall/req", 64'({stall, mem_req}), 64'd0);
        @(posedge clk) #1;
        idle_inputs();
    endtask

    task automatic mem_op(input logic rd, input logic wr, input logic mtr, input logic rw,
                          input logic [15:0] addr, input logic [15:0] wdata, input logic [15:0] rdata,
                          input logic [3:0] s, input int nwait, input int flush_at);
        int stalls;
        stalls = 0;
        @(posedge clk) #1;
        in_valid = 1; memread = rd; memwrite = wr; memtoreg = mtr; regwrite = rw;
        alu_result = addr; store_data = wdata; reg_write_select = s;
        push_exp(mtr ? rdata : addr, s, rw & (flush_at < 1 || flush_at > nwait));
        @(negedge clk);
        chk("issue stall/req", 64'({stall, mem_req}), 64'b10);
        if (stall) stalls++;
        for (int k = 1; k <= nwait; k++) begin
            @(posedge clk) #1;
            mem_ack   = (k == nwait);
            mem_rdata = (k == nwait) ? rdata : 16'hDEAD;
            flush     = (k == flush_at);
            @(negedge clk);
            if (stall) stalls++;
            chk("wait bus", 64'({mem_req, mem_we, mem_addr, mem_wdata, out_valid}),
                64'({1'b1, wr, addr, wdata, 1'b0}));
        end
        @(posedge clk) #1;
        idle_inputs();
        @(negedge clk);
        chk("done valid/stall/req", 64'({out_valid, stall, mem_req}), 64'b100);
        chk("stall cycles", 64'(stalls), 64'(nwait + 1));
        @(posedge clk) #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        idle_inputs();
        rst = 0;
        // Live load presented during reset must not stall or write back.
        in_valid = 1; memread = 1; alu_result = 16'h7777; reg_write_select = 4'hA; regwrite = 1;
        #12;
        chk("reset outputs",
            64'({mem_req, mem_we, stall, out_valid, regwrite_out, reg_write_data_out, reg_write_select_out}),
            64'd0);
`ifdef MEM_TIMEOUT_EN
        chk("reset mem_err", 64'(mem_err), 64'd0);
`endif
        idle_inputs();
        #5 rst = 1;

        // Idle with a stray ack: nothing moves.
        @(posedge clk) #1;
        mem_ack = 1;
        @(negedge clk);
        chk("idle outputs", 64'({out_valid, regwrite_out, stall, mem_req}), 64'd0);
        @(posedge clk) #1;
        mem_ack = 0;
        @(negedge clk);
        chk("stray ack ignored", 64'({mem_req, stall}), 64'd0);

        alu_op(16'h1234, 4'd5, 1'b1, 1'b0);
        alu_op(16'hFFFF, 4'd15, 1'b0, 1'b0);
        alu_op(16'h0001, 4'd0, 1'b1, 1'b1);

        mem_op(1, 0, 1, 1, 16'h0040, 16'h0000, 16'hBEEF, 4'd3, 3, 0);
        mem_op(1, 0, 1, 1, 16'h0100, 16'h0000, 16'h1357, 4'd7, 1, 0);
        mem_op(0, 1, 0, 0, 16'h0010, 16'hA5A5, 16'h0000, 4'd2, 2, 0);
        mem_op(1, 0, 1, 1, 16'h0050, 16'h0000, 16'h2468, 4'd9, 3, 2);
        mem_op(1, 1, 0, 1, 16'h0022, 16'h5A5A, 16'h0000, 4'd1, 1, 0);

        // Flushed load in IDLE: passes through without writeback or memory access.
        @(posedge clk) #1;
        in_valid = 1; memread = 1; memtoreg = 1; regwrite = 1; flush = 1;
        alu_result = 16'h0AAA; reg_write_select = 4'd4;
        push_exp(16'h0AAA, 4'd4, 1'b0);
        @(negedge clk);
        chk("flush idle stall", 64'(stall), 64'd0);
        @(posedge clk) #1;
        idle_inputs();
        @(negedge clk);
        chk("flush idle no req", 64'(mem_req), 64'd0);

        // Reset in the middle of WAIT abandons the load.
        @(posedge clk) #1;
        in_valid = 1; memread = 1; memtoreg = 1; regwrite = 1; alu_result = 16'h0060; reg_write_select = 4'd8;
        @(posedge clk) #1;
        @(negedge clk);
        chk("pre-reset req", 64'(mem_req), 64'd1);
        #2 rst = 0;
        #1;
        chk("async reset req/stall", 64'({mem_req, stall}), 64'd0);
        idle_inputs();
        #3 rst = 1;
        alu_op(16'h1234, 4'd5, 1'b1, 1'b0);

`ifdef MEM_TIMEOUT_EN
        begin : timeout_case
            int waits;
            waits = 0;
            @(posedge clk) #1;
            in_valid = 1; memread = 1; regwrite = 1; alu_result = 16'h0070; reg_write_select = 4'd6;
            push_exp(16'h0070, 4'd6, 1'b0);
            for (int k = 0; k < 20; k++) begin
                @(posedge clk) #1;
                @(negedge clk);
                if (!mem_req) break;
                waits++;
            end
            chk("timeout wait cycles", 64'(waits), 64'd15);
            chk("timeout mem_err", 64'(mem_err), 64'd1);
            @(posedge clk) #1;
            idle_inputs();
            @(negedge clk);
            chk("mem_err one cycle", 64'({mem_err, out_valid}), 64'd0);
        end
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
